// File: rtl/energy_channel_scaler.sv
// energy_channel_scaler: per-channel gain scaler with valid/ready output and framed energy reports.
// Optional saturating accumulation with overflow flag when SATURATE_EN is defined.
module energy_channel_scaler #(
  parameter int DATA_W = 8,
  parameter int CHANNELS = 4,
  parameter int GAIN = 2,
  parameter int ACC_W = 16,
  parameter int FRAME = 16,
  localparam int CH_W = $clog2(CHANNELS),
  localparam int OW = DATA_W + 4,
  localparam int CW = $clog2(FRAME)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [OW-1:0]     out_data,
  output logic              e_valid,
  output logic [CH_W-1:0]   e_ch,
  output logic [ACC_W-1:0]  e_sum,
  output logic              e_ovf,
  output logic              bad_ch
);
  logic [ACC_W-1:0] acc [CHANNELS];
  logic [CW-1:0]    cnt [CHANNELS];
  logic             accept, ch_ok, hit, last;
  logic [OW-1:0]    s;
  logic [ACC_W:0]   nxt;
  logic [ACC_W-1:0] acc_v;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign ch_ok = int'(in_ch) < CHANNELS;
  assign hit = accept && ch_ok;
  assign s = OW'(in_data) * OW'(GAIN);
  assign nxt = {1'b0, acc[in_ch]} + (ACC_W+1)'(s);
  assign last = cnt[in_ch] == CW'(FRAME - 1);
`ifdef SATURATE_EN
  logic ovf [CHANNELS];
  logic sat;
  assign sat = nxt[ACC_W];
  assign acc_v = sat ? '1 : nxt[ACC_W-1:0];
  // ovf is sticky within a frame and cleared on the report edge
  always_ff @(posedge clk) begin
    if (rst) begin
      e_ovf <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) ovf[i] <= 1'b0;
    end else begin
      e_ovf <= hit && last && (ovf[in_ch] || sat);
      if (hit) ovf[in_ch] <= !last && (ovf[in_ch] || sat);
    end
  end
`else
  logic unused_carry;
  assign unused_carry = nxt[ACC_W];
  assign acc_v = nxt[ACC_W-1:0];
  assign e_ovf = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch <= '0;
      out_data <= '0;
      e_valid <= 1'b0;
      e_ch <= '0;
      e_sum <= '0;
      bad_ch <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      bad_ch <= accept && !ch_ok;
      e_valid <= hit && last;
      if (hit) begin
        out_valid <= 1'b1;
        out_ch <= in_ch;
        out_data <= s;
      end else if (out_ready) out_valid <= 1'b0;
      if (hit && last) begin
        e_ch <= in_ch;
        e_sum <= acc_v;
        acc[in_ch] <= '0;
        cnt[in_ch] <= '0;
      end else if (hit) begin
        acc[in_ch] <= acc_v;
        cnt[in_ch] <= cnt[in_ch] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_energy_channel_scaler.sv
// tb_energy_channel_scaler: directed checks of scaling, handshake, framing, wrap/saturate and bad channels.
module tb_energy_channel_scaler;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, e_valid, e_ovf, bad_ch;
  logic [1:0] in_ch = 0, out_ch, e_ch;
  logic [7:0] in_data = 0, e_sum;
  logic [11:0] out_data;
  int n_chk = 0, n_fail = 0, e_cnt = 0, b_cnt = 0, e0, b0;
  energy_channel_scaler #(.DATA_W(8), .CHANNELS(3), .GAIN(2), .ACC_W(8), .FRAME(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .e_valid(e_valid), .e_ch(e_ch), .e_sum(e_sum), .e_ovf(e_ovf),
    .bad_ch(bad_ch));
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst) begin
    if (e_valid) e_cnt++;
    if (bad_ch) b_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    in_valid = 0;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask
  task automatic send(input logic [1:0] ch, input logic [7:0] d);
    in_valid = 1;
    in_ch = ch;
    in_data = d;
    step();
    in_valid = 0;
  endtask
  initial begin
    // reset state and quiet idle period
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_e_valid", e_valid, 0);
    check("rst_e_sum", e_sum, 0);
    check("rst_e_ovf", e_ovf, 0);
    check("rst_bad_ch", bad_ch, 0);
    check("rst_in_ready", in_ready, 1);
    e0 = e_cnt;
    b0 = b_cnt;
    repeat (10) step();
    check("idle_e_pulses", e_cnt - e0, 0);
    check("idle_bad_pulses", b_cnt - b0, 0);
    // basic scaling
    send(0, 25);
    check("s25_valid", out_valid, 1);
    check("s25_ch", out_ch, 0);
    check("s25_data", out_data, 50);
    send(0, 45);
    check("s45_data", out_data, 90);
    step();
    check("drain_valid", out_valid, 0);
    // backpressure: hold, then release without loss or duplication
    do_reset();
    out_ready = 0;
    send(2, 25);
    check("bp_valid", out_valid, 1);
    check("bp_data", out_data, 50);
    check("bp_in_ready", in_ready, 0);
    in_valid = 1;
    in_data = 45;
    step();
    check("bp_hold_data", out_data, 50);
    check("bp_hold_ch", out_ch, 2);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1;
    #1;
    check("bp_rel_ready", in_ready, 1);
    check("bp_rel_data", out_data, 50);
    step();
    in_valid = 0;
    check("bp_next_data", out_data, 90);
    check("bp_next_valid", out_valid, 1);
    step();
    check("bp_empty", out_valid, 0);
    // framing with interleaved channel
    do_reset();
    e0 = e_cnt;
    send(1, 10);
    send(2, 5);
    send(1, 20);
    send(1, 30);
    send(2, 5);
    check("fr_no_early", e_cnt - e0, 0);
    send(1, 40);
    check("fr_e_valid", e_valid, 1);
    check("fr_e_ch", e_ch, 1);
    check("fr_e_sum", e_sum, 200);
    check("fr_e_ovf", e_ovf, 0);
    step();
    check("fr_pulse_end", e_valid, 0);
    check("fr_once", e_cnt - e0, 1);
    repeat (4) send(1, 1);
    check("fr2_e_sum", e_sum, 8);
    check("fr2_e_ch", e_ch, 1);
    send(2, 5);
    send(2, 5);
    check("ch2_e_ch", e_ch, 2);
    check("ch2_e_sum", e_sum, 40);
    // accumulator wrap or saturation
    do_reset();
    repeat (4) send(2, 100);
    check("ov_e_valid", e_valid, 1);
`ifdef SATURATE_EN
    check("ov_e_sum", e_sum, 255);
    check("ov_e_ovf", e_ovf, 1);
`else
    check("ov_e_sum", e_sum, 32);
    check("ov_e_ovf", e_ovf, 0);
`endif
    repeat (4) send(2, 1);
    check("ov2_e_sum", e_sum, 8);
    check("ov2_e_ovf", e_ovf, 0);
    // bad channel mid-frame and reset mid-frame
    do_reset();
    send(0, 3);
    send(0, 3);
    rst = 1;
    step();
    rst = 0;
    b0 = b_cnt;
    send(0, 10);
    send(0, 10);
    send(3, 7);
    check("bad_pulse", bad_ch, 1);
    check("bad_no_out", out_valid, 0);
    step();
    check("bad_pulse_end", bad_ch, 0);
    check("bad_once", b_cnt - b0, 1);
    send(0, 10);
    check("post_bad_no_e", e_valid, 0);
    send(0, 10);
    check("post_rst_e_valid", e_valid, 1);
    check("post_rst_e_sum", e_sum, 80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
